keypad_scanner: RTL and testbench

- Upstream input stage of the charger's amount-entry path.
- Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and emits exactly one event per physical key press.
- Events: a digit (pressed pulse plus key_value), start, or clear.
- Runs on the 1000 Hz divided clock and feeds the amount manager directly.

---
 rtl/charger_pkg.sv | 47 ++++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/charger_pkg.sv
// Shared definitions for the charger amount-entry path: scan FSM states,
// key codes and the 4x4 keypad map.
package charger_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KEY_W   = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_e;

    localparam logic [KEY_W-1:0] KEY_A    = 4'hA;
    localparam logic [KEY_W-1:0] KEY_B    = 4'hB;
    localparam logic [KEY_W-1:0] KEY_C    = 4'hC;
    localparam logic [KEY_W-1:0] KEY_D    = 4'hD;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'hE;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'hF;

    // (row, column) -> key code; column 0 is the leftmost column
    function automatic logic [KEY_W-1:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [KEY_W-1:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, one event per physical press.
// Optional build macro KEYPAD_MULTI_KEY_REJECT_EN: reject (produce no event
// for) presses where more than one row of the scanned column reads low.
module keypad_scanner
    import charger_pkg::*;
#(
    parameter int unsigned SCAN_HOLD       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned CNT_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    output logic             pressed,
    output logic [KEY_W-1:0] key_value,
    output logic             start,
    output logic             clear
);

    localparam int unsigned       HOLD_W    = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]        rs;
    scan_state_e       state, state_d;
    logic [1:0]        col_idx, col_idx_d;
    logic [1:0]        row_idx, row_idx_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        col_n_d;
    logic              pressed_d, start_d, clear_d;
    logic [KEY_W-1:0]  key_value_d;
    logic [KEY_W-1:0]  code;
    logic              any_low;
    logic              row_low;
    logic              watch_low;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    logic              reject, reject_d;
    logic [3:0]        low_bits;
    logic              multi_low;
`endif

    // Lowest-index low row of an active-low row vector
    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rs)
    );

    assign any_low = ~&rs;
    assign row_low = ~rs[row_idx];
    assign code    = keymap(row_idx, col_idx);
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    assign low_bits  = ~rs;
    assign multi_low = (low_bits & (low_bits - 4'd1)) != 4'd0;
    // A rejected press waits for the whole frozen column to go quiet
    assign watch_low = reject ? any_low : row_low;
`else
    assign watch_low = row_low;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            hold_cnt  <= '0;
            cnt       <= '0;
            col_n     <= 4'b1110;
            pressed   <= 1'b0;
            start     <= 1'b0;
            clear     <= 1'b0;
            key_value <= '0;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
            reject    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            col_idx   <= col_idx_d;
            row_idx   <= row_idx_d;
            hold_cnt  <= hold_d;
            cnt       <= cnt_d;
            col_n     <= col_n_d;
            pressed   <= pressed_d;
            start     <= start_d;
            clear     <= clear_d;
            key_value <= key_value_d;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
            reject    <= reject_d;
`endif
        end
    end

    // Scan / debounce / hold / release sequencing and event generation
    always_comb begin
        state_d     = state;
        col_idx_d   = col_idx;
        row_idx_d   = row_idx;
        hold_d      = hold_cnt;
        cnt_d       = cnt;
        pressed_d   = 1'b0;
        start_d     = 1'b0;
        clear_d     = 1'b0;
        key_value_d = key_value;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
        reject_d    = reject;
`endif

        case (state)
            ST_SCAN: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_d = '0;
                    if (any_low) begin
                        row_idx_d = lowest_row(rs);
                        cnt_d     = '0;
                        state_d   = ST_DEBOUNCE;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
                        if (multi_low) begin
                            reject_d = 1'b1;
                            state_d  = ST_HELD;
                        end
`endif
                    end else begin
                        col_idx_d = col_idx + 2'd1;
                    end
                end else begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (!row_low) begin
                    state_d   = ST_SCAN;
                    col_idx_d = col_idx + 2'd1;
                    hold_d    = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_d   = cnt + CNT_W'(1);
                    state_d = ST_HELD;
                    if (code <= 4'd9) begin
                        pressed_d   = 1'b1;
                        key_value_d = code;
                    end else if (code == KEY_STAR) begin
                        start_d = 1'b1;
                    end else if (code == KEY_HASH) begin
                        clear_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
                // A second key in the column cancels the press outright
                if (multi_low) begin
                    reject_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_HELD;
                    col_idx_d   = col_idx;
                    hold_d      = hold_cnt;
                    pressed_d   = 1'b0;
                    start_d     = 1'b0;
                    clear_d     = 1'b0;
                    key_value_d = key_value;
                end
`endif
            end

            ST_HELD: begin
                if (!watch_low) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (watch_low) begin
                    state_d = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    cnt_d     = '0;
                    state_d   = ST_SCAN;
                    col_idx_d = col_idx + 2'd1;
                    hold_d    = '0;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
                    reject_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase

        col_n_d = ~(4'b0001 << col_idx_d);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model closes switches
// between column drives and rows; expected events come from the key legend.
`timescale 1us/1ns
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       pressed;
    logic [3:0] key_value;
    logic       start;
    logic       clear;

    logic [15:0] keys = '0;      // keys[r*4+c] = 1 while that switch is closed

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_pressed = 0;
    int n_start   = 0;
    int n_clear   = 0;
    int n_overlap = 0;
    int last_evt_cyc = 0;
    int exp_kv = 0;

    localparam int MAX_LAT = 39;

    keypad_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .pressed   (pressed),
        .key_value (key_value),
        .start     (start),
        .clear     (clear)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a row is pulled low through any closed switch whose column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Event monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (pressed) begin n_pressed++; last_evt_cyc = cyc; end
            if (start)   begin n_start++;   last_evt_cyc = cyc; end
            if (clear)   begin n_clear++;   last_evt_cyc = cyc; end
            if (int'(pressed) + int'(start) + int'(clear) > 1) n_overlap++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: legend of the keypad; kind 0=digit, 1=start, 2=clear, 3=silent
    function automatic int key_kind(input int idx, output int digit);
        string legend;
        byte   ch;
        legend = "123A456B789C*0#D";
        ch = legend[idx];
        digit = 0;
        if (ch >= "0" && ch <= "9") begin
            digit = int'(ch) - int'("0");
            return 0;
        end
        if (ch == "*") return 1;
        if (ch == "#") return 2;
        return 3;
    endfunction

    // One physical press with optional bounce on make and break
    task automatic run_key(input int idx, input int nb, input int lo, input int hi,
                           input int hold, input string tag);
        int p0, s0, c0, t0, kind, dig, lat;
        p0 = n_pressed; s0 = n_start; c0 = n_clear;
        for (int b = 0; b < nb; b++) begin
            keys[idx] = 1'b1; wait_cyc(lo);
            keys[idx] = 1'b0; wait_cyc(hi);
        end
        keys[idx] = 1'b1;
        t0 = cyc;
        wait_cyc(hold);
        lat = last_evt_cyc - t0;
        for (int b = 0; b < nb; b++) begin
            keys[idx] = 1'b0; wait_cyc(hi);
            keys[idx] = 1'b1; wait_cyc(lo);
        end
        keys[idx] = 1'b0;
        wait_cyc(60);
        kind = key_kind(idx, dig);
        if (kind == 0) exp_kv = dig;
        check({tag, ".pressed"}, n_pressed - p0, (kind == 0) ? 1 : 0);
        check({tag, ".start"},   n_start - s0,   (kind == 1) ? 1 : 0);
        check({tag, ".clear"},   n_clear - c0,   (kind == 2) ? 1 : 0);
        check({tag, ".key_value"}, int'(key_value), exp_kv);
        if (kind != 3)
            check({tag, ".latency_ok"}, int'(lat >= 22 && lat <= MAX_LAT), 1);
    endtask

    initial begin
        int p0, idx;
        // Reset state
        rst_n = 1'b0;
        wait_cyc(3);
        check("rst.col_n", int'(col_n), 4'b1110);
        check("rst.pulses", int'({pressed, start, clear}), 0);
        check("rst.key_value", int'(key_value), 0);
        rst_n = 1'b1;
        wait_cyc(5);
        check("scan.col_moves", int'(col_n != 4'b1110), 1);

        run_key(5, 0, 1, 1, 100, "key5");
        run_key(8, 4, 3, 2, 60, "key7_bounce");
        run_key(12, 0, 1, 1, 60, "star");
        run_key(14, 2, 2, 1, 60, "hash");

        // '1' held, then '9' pressed meanwhile: only '1' until '1' releases
        p0 = n_pressed;
        keys[0] = 1'b1; wait_cyc(60);
        keys[10] = 1'b1; wait_cyc(60);
        check("hold1.count", n_pressed - p0, 1);
        check("hold1.key_value", int'(key_value), 1);
        keys[0] = 1'b0; wait_cyc(80);
        check("then9.count", n_pressed - p0, 2);
        check("then9.key_value", int'(key_value), 9);
        keys[10] = 1'b0; wait_cyc(60);
        exp_kv = 9;

        // '3' and '6' share column 2
        p0 = n_pressed;
        keys[2] = 1'b1; keys[6] = 1'b1; wait_cyc(80);
        keys[2] = 1'b0; keys[6] = 1'b0; wait_cyc(80);
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
        check("dual.count", n_pressed - p0, 0);
        check("dual.key_value", int'(key_value), 9);
`else
        check("dual.count", n_pressed - p0, 1);
        check("dual.key_value", int'(key_value), 3);
        exp_kv = 3;
`endif

        // Reset while '2' is being debounced, then release reset with '2' held
        rst_n = 1'b0; wait_cyc(2); rst_n = 1'b1;
        exp_kv = 0;
        p0 = n_pressed;
        keys[1] = 1'b1;
        wait_cyc(15);
        check("rst2.no_early", n_pressed - p0, 0);
        rst_n = 1'b0;
        #1;
        check("rst2.col_n", int'(col_n), 4'b1110);
        check("rst2.pulses", int'({pressed, start, clear}), 0);
        check("rst2.key_value", int'(key_value), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(60);
        check("rst2.count", n_pressed - p0, 1);
        check("rst2.key_value_after", int'(key_value), 2);
        exp_kv = 2;
        keys[1] = 1'b0; wait_cyc(60);

        // Randomized presses with random bounce
        for (int k = 0; k < 12; k++) begin
            idx = int'($urandom_range(0, 15));
            run_key(idx, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), int'($urandom_range(45, 90)),
                    $sformatf("rnd%0d_k%0d", k, idx));
        end

        check("one_hot_pulses", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
